// File: rtl/s641_bist_ctrl.sv
// ============================================================================
// s641_bist_ctrl : LFSR-stimulus / MISR-compaction BIST controller for s641
// Rev 1.0
// ============================================================================
`default_nettype none

module s641_bist_ctrl #(
  parameter int unsigned NUM_PATTERNS = 1024,
  parameter int unsigned FLUSH_CYCLES = 20,
  parameter logic [34:0] FLUSH_VEC    = 35'h0,
  parameter logic [34:0] LFSR_SEED    = 35'h1,
  parameter logic [23:0] MISR_SEED    = 24'h0,
  parameter logic [23:0] GOLDEN_SIG   = 24'h0
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        START,
  input  logic        ABORT,
  output logic [34:0] CUT_IN,
  input  logic [23:0] CUT_OUT,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [23:0] SIGNATURE,
  output logic [15:0] PAT_CNT
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FLUSH = 3'd1;
  localparam logic [2:0] c_RUN   = 3'd2;
  localparam logic [2:0] c_CHECK = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam logic [15:0] c_NUM_PAT    = 16'(NUM_PATTERNS);
  localparam logic [7:0]  c_FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

  logic [2:0]  state_q,     state_d;
  logic [34:0] cut_in_q,    cut_in_d;
  logic [34:0] lfsr_q,      lfsr_d;
  logic [23:0] misr_q,      misr_d;
  logic [15:0] pat_cnt_q,   pat_cnt_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;
  logic        pass_q,      pass_d;

  logic [34:0] lfsr_nxt;
  logic [23:0] misr_nxt;
  logic        misr_fb;

  // x^35+x^33+1 Fibonacci shift; x^24+x^23+x^22+x^17+1 MISR
  assign lfsr_nxt = {lfsr_q[33:0], lfsr_q[34] ^ lfsr_q[32]};
  assign misr_fb  = misr_q[23] ^ misr_q[22] ^ misr_q[21] ^ misr_q[16];
  assign misr_nxt = {misr_q[22:0], misr_fb} ^ CUT_OUT;

  always_comb begin
    state_d     = state_q;
    cut_in_d    = cut_in_q;
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    pat_cnt_d   = pat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pass_d      = pass_q;

    if (ABORT) begin
      state_d  = c_IDLE;
      pass_d   = 1'b0;
      cut_in_d = FLUSH_VEC;
    end else begin
      case (state_q)
        c_IDLE, c_DONE: begin
          cut_in_d = FLUSH_VEC;
          if (START) begin
            state_d     = c_FLUSH;
            flush_cnt_d = 8'd0;
            misr_d      = MISR_SEED;
            pat_cnt_d   = 16'd0;
            lfsr_d      = LFSR_SEED;
            pass_d      = 1'b0;
          end
        end
        c_FLUSH: begin
          cut_in_d    = FLUSH_VEC;
          flush_cnt_d = flush_cnt_q + 8'd1;
          if (flush_cnt_q == c_FLUSH_LAST) begin
            state_d  = c_RUN;
            lfsr_d   = LFSR_SEED;
            cut_in_d = LFSR_SEED;
          end
        end
        c_RUN: begin
          misr_d   = misr_nxt;
          lfsr_d   = lfsr_nxt;
          cut_in_d = lfsr_nxt;
          if (pat_cnt_q != c_NUM_PAT) begin
            pat_cnt_d = pat_cnt_q + 16'd1;
          end
          if (pat_cnt_d == c_NUM_PAT) begin
            state_d  = c_CHECK;
            cut_in_d = FLUSH_VEC;
          end
        end
        c_CHECK: begin
          pass_d  = (misr_q == GOLDEN_SIG);
          state_d = c_DONE;
        end
        default: begin
          state_d  = c_IDLE;
          cut_in_d = FLUSH_VEC;
          pass_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q     <= c_IDLE;
      cut_in_q    <= FLUSH_VEC;
      lfsr_q      <= LFSR_SEED;
      misr_q      <= MISR_SEED;
      pat_cnt_q   <= 16'd0;
      flush_cnt_q <= 8'd0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cut_in_q    <= cut_in_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
      pat_cnt_q   <= pat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      pass_q      <= pass_d;
    end
  end

  assign CUT_IN    = cut_in_q;
  assign BUSY      = (state_q == c_FLUSH) || (state_q == c_RUN) || (state_q == c_CHECK);
  assign DONE      = (state_q == c_DONE);
  assign PASS      = pass_q && (state_q == c_DONE);
  assign SIGNATURE = misr_q;
  assign PAT_CNT   = pat_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_s641_bist_ctrl.sv
// ============================================================================
// tb_s641_bist_ctrl : directed bench for s641_bist_ctrl with a stand-in core
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_s641_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, abort_a, start_b, abort_b, rst_e, start_e, abort_e;
  logic [23:0] cut_out_a, cut_out_b;

  logic [34:0] cut_in_a, cut_in_b, cut_in_c, cut_in_d, cut_in_e;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
  logic        busy_d, done_d, pass_d, busy_e, done_e, pass_e;
  logic [23:0] sig_a, sig_b, sig_c, sig_d, sig_e;
  logic [15:0] pat_a, pat_b, pat_c, pat_d, pat_e;

  // Stand-in core: 19-bit shift state fed by input parity, outputs mix input and state
  logic [18:0] core_s;
  logic [23:0] cut_out_e;
  always @(posedge clk) begin
    if (rst_e) core_s <= '0;
    else       core_s <= {core_s[17:0], ^cut_in_e};
  end
  assign cut_out_e = cut_in_e[23:0] ^ {core_s, core_s[18:14]};

  s641_bist_ctrl #(.NUM_PATTERNS(4), .FLUSH_CYCLES(2)) u_a (
    .CK(clk), .RST(rst), .START(start_a), .ABORT(abort_a), .CUT_IN(cut_in_a),
    .CUT_OUT(cut_out_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a),
    .SIGNATURE(sig_a), .PAT_CNT(pat_a));

  s641_bist_ctrl #(.NUM_PATTERNS(4), .FLUSH_CYCLES(2), .LFSR_SEED(35'h400000000)) u_d (
    .CK(clk), .RST(rst), .START(start_a), .ABORT(abort_a), .CUT_IN(cut_in_d),
    .CUT_OUT(cut_out_a), .BUSY(busy_d), .DONE(done_d), .PASS(pass_d),
    .SIGNATURE(sig_d), .PAT_CNT(pat_d));

  s641_bist_ctrl #(.NUM_PATTERNS(2), .FLUSH_CYCLES(2), .GOLDEN_SIG(24'h0)) u_b (
    .CK(clk), .RST(rst), .START(start_b), .ABORT(abort_b), .CUT_IN(cut_in_b),
    .CUT_OUT(cut_out_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b),
    .SIGNATURE(sig_b), .PAT_CNT(pat_b));

  s641_bist_ctrl #(.NUM_PATTERNS(2), .FLUSH_CYCLES(2), .GOLDEN_SIG(24'h000003)) u_c (
    .CK(clk), .RST(rst), .START(start_b), .ABORT(abort_b), .CUT_IN(cut_in_c),
    .CUT_OUT(cut_out_b), .BUSY(busy_c), .DONE(done_c), .PASS(pass_c),
    .SIGNATURE(sig_c), .PAT_CNT(pat_c));

  s641_bist_ctrl #(.NUM_PATTERNS(1024), .FLUSH_CYCLES(20)) u_e (
    .CK(clk), .RST(rst_e), .START(start_e), .ABORT(abort_e), .CUT_IN(cut_in_e),
    .CUT_OUT(cut_out_e), .BUSY(busy_e), .DONE(done_e), .PASS(pass_e),
    .SIGNATURE(sig_e), .PAT_CNT(pat_e));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [23:0] misr_f(input logic [23:0] m, input logic [23:0] r);
    logic [23:0] n;
    n[0] = m[23] ^ m[22] ^ m[21] ^ m[16] ^ r[0];
    for (int i = 1; i < 24; i++) n[i] = m[i-1] ^ r[i];
    return n;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  logic [34:0] exp_a [4];
  logic [34:0] exp_d [4];
  logic [23:0] ref_sig, first_sig;

  initial begin
    exp_a = '{35'h1, 35'h2, 35'h4, 35'h8};
    exp_d = '{35'h400000000, 35'h1, 35'h2, 35'h4};
    first_sig = '0;
    rst = 1'b1; rst_e = 1'b1;
    start_a = 0; abort_a = 0; start_b = 0; abort_b = 0; start_e = 0; abort_e = 0;
    cut_out_a = '0; cut_out_b = '0;
    tick(); tick();
    rst = 1'b0; rst_e = 1'b0;

    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_sig", sig_a, 0);
    check("rst_pat", pat_a, 0);
    check("rst_cut_in", cut_in_a, 0);
    tick();
    check("idle_stays", busy_a, 0);

    // NUM_PATTERNS=4, FLUSH_CYCLES=2, CUT_OUT=0
    start_a = 1; tick(); start_a = 0;
    check("flush_busy", busy_a, 1);
    check("flush_cut_in", cut_in_a, 0);
    tick(); tick();
    for (int j = 0; j < 4; j++) begin
      check($sformatf("run_cut_in_%0d", j), cut_in_a, exp_a[j]);
      check($sformatf("lfsr_wrap_%0d", j), cut_in_d, exp_d[j]);
      check($sformatf("run_done_low_%0d", j), done_a, 0);
      tick();
    end
    check("check_done_low", done_a, 0);
    check("check_busy", busy_a, 1);
    check("check_pat", pat_a, 4);
    check("check_cut_in", cut_in_a, 0);
    tick();
    check("done_at_7", done_a, 1);
    check("done_busy", busy_a, 0);
    check("done_sig", sig_a, 0);
    check("done_pass", pass_a, 1);
    check("done_pat", pat_a, 4);
    tick();
    check("done_hold_pat", pat_a, 4);
    check("done_hold_pass", pass_a, 1);

    // ABORT during RUN with simultaneous START
    start_a = 1; tick(); start_a = 0;
    check("restart_pat0", pat_a, 0);
    check("restart_pass0", pass_a, 0);
    tick(); tick();
    tick(); tick();
    check("abort_pre_pat", pat_a, 2);
    abort_a = 1; start_a = 1; tick(); abort_a = 0; start_a = 0;
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_pat_held", pat_a, 2);
    check("abort_cut_in", cut_in_a, 0);
    check("abort_pass", pass_a, 0);
    tick();
    check("abort_stays_idle", busy_a, 0);
    start_a = 1; tick(); start_a = 0;
    check("post_abort_busy", busy_a, 1);
    check("post_abort_pat0", pat_a, 0);

    // NUM_PATTERNS=2 with CUT_OUT=1 in both RUN cycles
    start_b = 1; tick(); start_b = 0;
    tick(); tick();
    cut_out_b = 24'h000001;
    tick(); tick();
    cut_out_b = 24'h0;
    check("misr_pass_before_done", pass_b, 0);
    tick();
    check("misr_done_b", done_b, 1);
    check("misr_sig_b", sig_b, 24'h000003);
    check("misr_pass_b", pass_b, 0);
    check("misr_sig_c", sig_c, 24'h000003);
    check("misr_pass_c", pass_c, 1);

    // Full 1024-pattern run against the stand-in core, then rerun from DONE
    for (int r = 0; r < 2; r++) begin
      start_e = 1; tick(); start_e = 0;
      repeat (20) tick();
      check($sformatf("full_first_cut_in_%0d", r), cut_in_e, 35'h1);
      ref_sig = 24'h0;
      for (int j = 0; j < 1024; j++) begin
        ref_sig = misr_f(ref_sig, cut_out_e);
        tick();
      end
      check($sformatf("full_check_done_low_%0d", r), done_e, 0);
      tick();
      check($sformatf("full_done_%0d", r), done_e, 1);
      check($sformatf("full_sig_%0d", r), sig_e, ref_sig);
      check($sformatf("full_pat_%0d", r), pat_e, 1024);
      check($sformatf("full_pass_%0d", r), pass_e, (ref_sig == 24'h0));
      if (r == 0) first_sig = ref_sig;
      else        check("full_rerun_same_sig", sig_e, first_sig);
    end

    // Reset mid-RUN at pattern 5
    start_e = 1; tick(); start_e = 0;
    repeat (20) tick();
    repeat (4) tick();
    check("midrun_pat4", pat_e, 4);
    rst_e = 1; tick(); rst_e = 0;
    check("midrun_rst_busy", busy_e, 0);
    check("midrun_rst_done", done_e, 0);
    check("midrun_rst_sig", sig_e, 0);
    check("midrun_rst_pat", pat_e, 0);
    check("midrun_rst_cut_in", cut_in_e, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/s641_bist_ctrl.md
Name: s641_bist_ctrl

Overview:
- Built-in self-test controller for the s641 sequential benchmark core.
- Drives pseudo-random stimulus into the core's 35 primary inputs and reads back its 24 primary outputs.
- Compacts the outputs into a 24-bit MISR signature and compares it against a golden value.
- Sits beside the core in the test wrapper; it is the stimulus writer and response reader for the core's input/output interface.

Parameters:
- NUM_PATTERNS, 1024: number of RUN cycles (patterns applied and captured), range 1..65535.
- FLUSH_CYCLES, 20: cycles of FLUSH_VEC applied before RUN to settle the core's 19 flip-flops, range 1..255.
- FLUSH_VEC, 35'h0: stimulus driven during FLUSH.
- LFSR_SEED, 35'h1: LFSR load value; must be nonzero.
- MISR_SEED, 24'h0: MISR load value.
- GOLDEN_SIG, 24'h0: expected final signature.

Ports:
- CK  in  1  clock, rising-edge; also clocks the core.
- RST  in  1  synchronous reset, active-high.
- START  in  1  one-cycle pulse; starts a test, honoured only in IDLE or DONE.
- ABORT  in  1  returns to IDLE at the next edge from any state.
- CUT_IN  out  35  registered stimulus to the core's inputs; bit 0 = G1 … bit 34 = G36 (G7 absent).
- CUT_OUT  in  24  core's primary outputs, sampled combinationally; bit order fixed by the wrapper.
- BUSY  out  1  high in FLUSH, RUN and CHECK.
- DONE  out  1  high in DONE.
- PASS  out  1  valid while DONE=1; 0 otherwise.
- SIGNATURE  out  24  current MISR contents.
- PAT_CNT  out  16  patterns captured so far.

Behaviour:
Reset (RST=1 at an edge):
- State IDLE; CUT_IN=FLUSH_VEC; BUSY=0, DONE=0, PASS=0.
- SIGNATURE=MISR_SEED; PAT_CNT=0; LFSR=LFSR_SEED; flush counter=0.
- RST has priority over ABORT and START, including mid-RUN.

States:
- IDLE:
  - CUT_IN=FLUSH_VEC.
  - START -> FLUSH: load flush counter=0, MISR=MISR_SEED, PAT_CNT=0, LFSR=LFSR_SEED.
- FLUSH:
  - CUT_IN=FLUSH_VEC; counter increments each cycle; MISR is not updated.
  - After FLUSH_CYCLES cycles in FLUSH -> RUN; on that same edge CUT_IN <= LFSR_SEED.
- RUN (each cycle, CUT_OUT reflects the current CUT_IN and core state):
  - At the edge: MISR <= misr_next(MISR, CUT_OUT); PAT_CNT += 1; LFSR advances; CUT_IN <= advanced LFSR.
  - When PAT_CNT reaches NUM_PATTERNS on an edge -> CHECK; CUT_IN <= FLUSH_VEC on that edge.
- CHECK:
  - One cycle.
  - PASS <= (MISR == GOLDEN_SIG); -> DONE.
- DONE:
  - Holds SIGNATURE, PAT_CNT and PASS.
  - START -> FLUSH, reinitialising as from IDLE.
- ABORT in any state -> IDLE:
  - PASS=0; CUT_IN=FLUSH_VEC.
  - SIGNATURE and PAT_CNT are held, not cleared.
  - ABORT beats a simultaneous START.

Arithmetic:
- LFSR, 35-bit Fibonacci, x^35+x^33+1: nxt[0]=l[34]^l[32]; nxt[i]=l[i-1] for i=1..34. Never all-zero.
- MISR, 24-bit, x^24+x^23+x^22+x^17+1:
  - fb = m[23]^m[22]^m[21]^m[16].
  - nxt[0] = fb ^ r[0].
  - nxt[i] = m[i-1] ^ r[i] for i=1..23.
- PAT_CNT saturates at NUM_PATTERNS; no wrap.

Latency:
- Total test length is FLUSH_CYCLES + NUM_PATTERNS + 1 cycles from the START edge to DONE=1.
- Exactly NUM_PATTERNS MISR updates occur.

Test Plan:
- Reset mid-RUN (RST high 1 cycle at pattern 5) -> next cycle BUSY=0, DONE=0, SIGNATURE=000000, PAT_CNT=0, CUT_IN=FLUSH_VEC.
- NUM_PATTERNS=4, FLUSH_CYCLES=2, CUT_OUT tied 0 ->
  - CUT_IN in RUN is 35'h1, 35'h2, 35'h4, 35'h8.
  - DONE asserts 7 cycles after the START edge.
  - SIGNATURE=000000; PASS=1.
- NUM_PATTERNS=2, CUT_OUT=24'h000001 in both RUN cycles -> SIGNATURE=24'h000003; PASS=0 with GOLDEN_SIG=0, PASS=1 with GOLDEN_SIG=24'h000003.
- LFSR wrap of taps: seed 35'h400000000 -> next CUT_IN 35'h000000001 (bit34 feedback), then 35'h000000002.
- ABORT on RUN pattern 2, with START asserted the same cycle -> IDLE, BUSY=0, DONE=0, PAT_CNT=2 held; a later START restarts with PAT_CNT=0.
- Full run against the gate-level core, NUM_PATTERNS=1024 -> SIGNATURE matches the reference-model MISR computed from the simulated core; START in DONE reruns and reproduces the identical signature.
